// File: rtl/axi_sim_ctrl.sv
// AXI4-Lite simulation control block: test-exit mailbox (TOHOST), a free-running
// 64-bit cycle counter with atomic LO/HI readout, and a byte-maskable scratch register.
module axi_sim_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic [31:0] AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,
    input  logic [31:0] ARADDR,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RVALID,
    input  logic        RREADY,
    output logic        done,
    output logic        pass,
    output logic [30:0] exit_code
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        REG_TOHOST   = 2'd0,
        REG_CYCLE_LO = 2'd1,
        REG_CYCLE_HI = 2'd2,
        REG_SCRATCH  = 2'd3
    } reg_sel_t;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_RESP } r_state_t;

    w_state_t    w_state;
    r_state_t    r_state;
    logic        aw_held;
    logic        w_held;
    logic [31:2] aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;

    logic [63:0] counter;
    logic [31:0] shadow;
    logic [31:0] scratch;

    // Byte-lane bits of the addresses are never decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{AWADDR[1:0], ARADDR[1:0]};

    logic        aw_fire;
    logic        w_fire;
    logic        ar_fire;
    logic [31:2] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_commit;
    reg_sel_t    wr_sel;
    logic [1:0]  wr_resp;
    logic        wr_ok;
    logic        finish;
    logic        scratch_we;
    reg_sel_t    rd_sel;
    logic        rd_in_win;
    logic [31:0] rd_data_nxt;
    logic [1:0]  rd_resp_nxt;

    // NOTE: every signal gets a default at the top of the block so no path leaves it
    // unassigned; that is what keeps this combinational logic free of latches.
    always_comb begin
        aw_fire     = AWVALID && AWREADY;
        w_fire      = WVALID && WREADY;
        ar_fire     = ARVALID && ARREADY;

        // A channel captured earlier wins over the live bus value.
        wr_addr     = aw_held ? aw_addr_q : AWADDR[31:2];
        wr_data     = w_held  ? w_data_q  : WDATA;
        wr_strb     = w_held  ? w_strb_q  : WSTRB;
        wr_commit   = (w_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);
        wr_sel      = reg_sel_t'(wr_addr[3:2]);
        wr_resp     = RESP_OKAY;

        if (wr_addr[31:4] != BASE_ADDR[31:4]) begin
            wr_resp = RESP_SLVERR;
        end else begin
            case (wr_sel)
                REG_CYCLE_LO, REG_CYCLE_HI: wr_resp = RESP_SLVERR;
                REG_TOHOST:   if (wr_strb != 4'hF) wr_resp = RESP_SLVERR;
                default:      wr_resp = RESP_OKAY;
            endcase
        end

        wr_ok       = wr_commit && (wr_resp == RESP_OKAY);
        finish      = wr_ok && (wr_sel == REG_TOHOST) && wr_data[0] && !done;
        scratch_we  = wr_ok && (wr_sel == REG_SCRATCH);

        rd_sel      = reg_sel_t'(ARADDR[3:2]);
        rd_in_win   = (ARADDR[31:4] == BASE_ADDR[31:4]);
        rd_data_nxt = 32'd0;
        rd_resp_nxt = RESP_OKAY;
        if (!rd_in_win) begin
            rd_resp_nxt = RESP_SLVERR;
        end else begin
            case (rd_sel)
                REG_CYCLE_LO: rd_data_nxt = counter[31:0];
                REG_CYCLE_HI: rd_data_nxt = shadow;
                REG_SCRATCH:  rd_data_nxt = scratch;
                default:      rd_data_nxt = 32'd0;
            endcase
        end
    end

    // NOTE: state registers are updated with non-blocking assignments so every
    // always_ff samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state   <= W_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            AWREADY   <= 1'b0;
            WREADY    <= 1'b0;
            BVALID    <= 1'b0;
            BRESP     <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (wr_commit) begin
                        w_state <= W_RESP;
                        aw_held <= 1'b1;
                        w_held  <= 1'b1;
                        AWREADY <= 1'b0;
                        WREADY  <= 1'b0;
                        BVALID  <= 1'b1;
                        BRESP   <= wr_resp;
                    end else begin
                        if (aw_fire) begin
                            aw_held   <= 1'b1;
                            aw_addr_q <= AWADDR[31:2];
                        end
                        if (w_fire) begin
                            w_held   <= 1'b1;
                            w_data_q <= WDATA;
                            w_strb_q <= WSTRB;
                        end
                        AWREADY <= !(aw_held || aw_fire);
                        WREADY  <= !(w_held || w_fire);
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        w_state <= W_IDLE;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        AWREADY <= 1'b1;
                        WREADY  <= 1'b1;
                        BVALID  <= 1'b0;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= R_IDLE;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RDATA   <= '0;
            RRESP   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        r_state <= R_RESP;
                        ARREADY <= 1'b0;
                        RVALID  <= 1'b1;
                        RDATA   <= rd_data_nxt;
                        RRESP   <= rd_resp_nxt;
                    end else begin
                        ARREADY <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (RREADY) begin
                        r_state <= R_IDLE;
                        ARREADY <= 1'b1;
                        RVALID  <= 1'b0;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            done      <= 1'b0;
            pass      <= 1'b0;
            exit_code <= '0;
            counter   <= '0;
            shadow    <= '0;
            scratch   <= '0;
        end else begin
            if (!done) counter <= counter + 64'd1;

            if (finish) begin
                done      <= 1'b1;
                exit_code <= wr_data[31:1];
                pass      <= (wr_data[31:1] == 31'd0);
            end

            for (int b = 0; b < 4; b++) begin
                if (scratch_we && wr_strb[b]) scratch[8*b +: 8] <= wr_data[8*b +: 8];
            end

            // Capturing the upper half on the LO read makes a LO-then-HI pair atomic.
            if (ar_fire && rd_in_win && (rd_sel == REG_CYCLE_LO)) shadow <= counter[63:32];
        end
    end

endmodule

// File: tb/tb_axi_sim_ctrl.sv
// Self-checking bench for axi_sim_ctrl: table-driven register accesses through a
// response scoreboard, plus hand-written sequences for the multi-cycle corner cases.
module tb_axi_sim_ctrl;

    localparam logic [31:0] BASE    = 32'h1000_0000;
    localparam logic [31:0] A_HOST  = BASE + 32'h0;
    localparam logic [31:0] A_LO    = BASE + 32'h4;
    localparam logic [31:0] A_HI    = BASE + 32'h8;
    localparam logic [31:0] A_SCR   = BASE + 32'hC;
    localparam logic [31:0] A_OUT   = BASE + 32'h10;
    localparam logic [1:0]  OKAY    = 2'b00;
    localparam logic [1:0]  SLVERR  = 2'b10;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [31:0] AWADDR = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [31:0] ARADDR = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b0;
    logic        done;
    logic        pass;
    logic [30:0] exit_code;

    axi_sim_ctrl #(.BASE_ADDR(BASE)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .done(done), .pass(pass), .exit_code(exit_code)
    );

    always #5 ACLK = ~ACLK;

    int unsigned cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        string      name;
        logic [1:0] resp;
        logic [31:0] data;
        bit         chk_data;
    } exp_t;

    exp_t wq[$];
    exp_t rq[$];

    task automatic push_w(input string name, input logic [1:0] resp);
        exp_t e;
        e.name = name; e.resp = resp; e.data = '0; e.chk_data = 1'b0;
        wq.push_back(e);
    endtask

    task automatic axi_write(input string name, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] resp);
        exp_t e;
        bit aw_p, w_p, aw_f, w_f, got;
        push_w(name, resp);
        @(negedge ACLK);
        AWADDR = addr; AWVALID = 1'b1;
        WDATA = data; WSTRB = strb; WVALID = 1'b1;
        BREADY = 1'b1;
        aw_p = 1'b1; w_p = 1'b1;
        for (int i = 0; i < 40 && (aw_p || w_p); i++) begin
            aw_f = AWVALID && AWREADY;
            w_f  = WVALID && WREADY;
            @(negedge ACLK);
            if (aw_f) begin AWVALID = 1'b0; aw_p = 1'b0; end
            if (w_f)  begin WVALID  = 1'b0; w_p  = 1'b0; end
        end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (BVALID) got = 1'b1;
            else @(negedge ACLK);
        end
        e = wq.pop_front();
        if (!got) begin
            check({e.name, " bvalid timeout"}, 64'(got), 64'(1));
            AWVALID = 1'b0; WVALID = 1'b0;
        end else begin
            check({e.name, " bresp"}, 64'(BRESP), 64'(e.resp));
            @(negedge ACLK);
        end
        BREADY = 1'b0;
    endtask

    task automatic axi_read(input string name, input logic [31:0] addr, input logic [31:0] exp_data,
                            input bit chk, input logic [1:0] resp,
                            output logic [31:0] data, output int unsigned hs_cyc);
        exp_t e;
        bit got;
        e.name = name; e.resp = resp; e.data = exp_data; e.chk_data = chk;
        rq.push_back(e);
        data = '0; hs_cyc = 0;
        @(negedge ACLK);
        ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            got = ARREADY;
            if (got) hs_cyc = cyc;
            @(negedge ACLK);
        end
        ARVALID = 1'b0;
        if (got) begin
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                if (RVALID) got = 1'b1;
                else @(negedge ACLK);
            end
        end
        e = rq.pop_front();
        if (!got) begin
            check({e.name, " rvalid timeout"}, 64'(got), 64'(1));
        end else begin
            data = RDATA;
            check({e.name, " rresp"}, 64'(RRESP), 64'(e.resp));
            if (e.chk_data) check({e.name, " rdata"}, 64'(RDATA), 64'(e.data));
            @(negedge ACLK);
        end
        RREADY = 1'b0;
    endtask

    int unsigned rel_cyc;

    task automatic apply_reset();
        @(negedge ACLK);
        ARESETn = 1'b0;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0; BREADY = 1'b0; RREADY = 1'b0;
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        rel_cyc = cyc;
        @(negedge ACLK);
    endtask

    typedef struct {
        string       name;
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
    } vec_t;

    vec_t vecs[15];

    logic [31:0] rd, lo_a, lo_b;
    int unsigned hs, hs_b;
    exp_t e;

    initial begin
        // Register-map vectors: for reads, data is the expected RDATA.
        vecs[0]  = '{"scr reset",    1'b0, A_SCR,  32'h0000_0000, 4'h0, OKAY};
        vecs[1]  = '{"scr wr 0101",  1'b1, A_SCR,  32'hAABB_CCDD, 4'h5, OKAY};
        vecs[2]  = '{"scr rd 0101",  1'b0, A_SCR,  32'h00BB_00DD, 4'h0, OKAY};
        vecs[3]  = '{"scr wr strb0", 1'b1, A_SCR,  32'h1122_3344, 4'h0, OKAY};
        vecs[4]  = '{"scr rd strb0", 1'b0, A_SCR,  32'h00BB_00DD, 4'h0, OKAY};
        vecs[5]  = '{"scr wr 1010",  1'b1, A_SCR,  32'h1122_3344, 4'hA, OKAY};
        vecs[6]  = '{"scr rd 1010",  1'b0, A_SCR,  32'h11BB_33DD, 4'h0, OKAY};
        vecs[7]  = '{"wr cycle_lo",  1'b1, A_LO,   32'hFFFF_FFFF, 4'hF, SLVERR};
        vecs[8]  = '{"wr cycle_hi",  1'b1, A_HI,   32'hFFFF_FFFF, 4'hF, SLVERR};
        vecs[9]  = '{"rd out win",   1'b0, A_OUT,  32'h0000_0000, 4'h0, SLVERR};
        vecs[10] = '{"host strb3",   1'b1, A_HOST, 32'h0000_0001, 4'h3, SLVERR};
        vecs[11] = '{"rd tohost",    1'b0, A_HOST, 32'h0000_0000, 4'h0, OKAY};
        vecs[12] = '{"wr out win",   1'b1, A_OUT,  32'hDEAD_BEEF, 4'hF, SLVERR};
        vecs[13] = '{"scr unchanged",1'b0, A_SCR,  32'h11BB_33DD, 4'h0, OKAY};
        vecs[14] = '{"host bit0=0",  1'b1, A_HOST, 32'h0000_0006, 4'hF, OKAY};

        // Outputs while reset is held from time zero.
        #12;
        check("rst awready", 64'(AWREADY), 64'(0));
        check("rst wready",  64'(WREADY),  64'(0));
        check("rst arready", 64'(ARREADY), 64'(0));
        check("rst bvalid",  64'(BVALID),  64'(0));
        check("rst rvalid",  64'(RVALID),  64'(0));
        check("rst rdata",   64'(RDATA),   64'(0));
        check("rst status",  64'({done, pass, exit_code, BRESP, RRESP}), 64'(0));

        apply_reset();
        check("post-rst readies", 64'({AWREADY, WREADY, ARREADY}), 64'(3'b111));

        // Counter starts at 0 on release and counts every edge since.
        axi_read("lo first", A_LO, 32'h0, 1'b0, OKAY, lo_a, hs);
        check("counter from reset", 64'(lo_a), 64'(hs - rel_cyc));

        foreach (vecs[i]) begin
            if (vecs[i].is_wr) axi_write(vecs[i].name, vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp);
            else axi_read(vecs[i].name, vecs[i].addr, vecs[i].data, 1'b1, vecs[i].resp, rd, hs);
        end
        check("no done after rejected/bit0=0", 64'({done, exit_code}), 64'(0));

        axi_read("lo later", A_LO, 32'h0, 1'b0, OKAY, lo_a, hs);
        check("counter running", 64'(lo_a), 64'(hs - rel_cyc));

        // W three cycles ahead of AW, response stalled for five cycles.
        push_w("w-first", OKAY);
        @(negedge ACLK);
        check("w-first wready", 64'(WREADY), 64'(1));
        WDATA = 32'hCAFE_F00D; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b0;
        @(negedge ACLK);
        WVALID = 1'b0;
        repeat (2) @(negedge ACLK);
        check("w held blocks wready", 64'(WREADY), 64'(0));
        check("no early bvalid", 64'(BVALID), 64'(0));
        AWADDR = A_SCR; AWVALID = 1'b1;
        check("aw ready after w", 64'(AWREADY), 64'(1));
        @(negedge ACLK);
        AWVALID = 1'b0;
        e = wq.pop_front();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("%s bvalid stable %0d", e.name, i), 64'({BVALID, BRESP}), 64'({1'b1, e.resp}));
            @(negedge ACLK);
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("single response %0d", i), 64'(BVALID), 64'(0));
            @(negedge ACLK);
        end
        axi_read("scr after w-first", A_SCR, 32'hCAFE_F00D, 1'b1, OKAY, rd, hs);

        // Write and read of SCRATCH handshaking in the same cycle.
        fork
            axi_write("concurrent wr", A_SCR, 32'h1234_5678, 4'hF, OKAY);
            axi_read("concurrent rd old", A_SCR, 32'hCAFE_F00D, 1'b1, OKAY, rd, hs);
        join
        axi_read("scr new", A_SCR, 32'h1234_5678, 1'b1, OKAY, rd, hs);

        // Atomic 64-bit read across a LO->HI carry.
        @(negedge ACLK);
        force dut.counter = 64'h0000_0000_FFFF_FFFF;
        axi_read("lo at carry", A_LO, 32'hFFFF_FFFF, 1'b1, OKAY, rd, hs);
        release dut.counter;
        repeat (2) @(negedge ACLK);
        axi_read("hi shadow", A_HI, 32'h0, 1'b1, OKAY, rd, hs);

        // Passing exit.
        axi_write("tohost pass", A_HOST, 32'h0000_0001, 4'hF, OKAY);
        check("done/pass/exit", 64'({done, pass, exit_code}), 64'({1'b1, 1'b1, 31'd0}));
        axi_read("lo frozen a", A_LO, 32'h0, 1'b0, OKAY, lo_a, hs);
        repeat (10) @(negedge ACLK);
        axi_read("lo frozen b", A_LO, 32'h0, 1'b0, OKAY, lo_b, hs_b);
        check("counter frozen", 64'(lo_b), 64'(lo_a));
        check("done sticky", 64'(done), 64'(1));

        // Reset with a write and a read response both pending.
        @(negedge ACLK);
        AWADDR = A_SCR; AWVALID = 1'b1; WDATA = 32'h5555_5555; WSTRB = 4'hF; WVALID = 1'b1;
        ARADDR = A_SCR; ARVALID = 1'b1; BREADY = 1'b0; RREADY = 1'b0;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        check("pending before reset", 64'({BVALID, RVALID}), 64'(2'b11));
        #2 ARESETn = 1'b0;
        #1;
        check("async clear valids", 64'({BVALID, RVALID}), 64'(0));
        check("async clear readies", 64'({AWREADY, WREADY, ARREADY}), 64'(0));
        check("async clear status", 64'({done, pass, exit_code, RDATA}), 64'(0));
        @(negedge ACLK);
        ARESETn = 1'b1;
        rel_cyc = cyc;
        BREADY = 1'b1; RREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            check($sformatf("abandoned resp %0d", i), 64'({BVALID, RVALID}), 64'(0));
        end
        BREADY = 1'b0; RREADY = 1'b0;
        check("readies after abort", 64'({AWREADY, WREADY, ARREADY}), 64'(3'b111));
        axi_read("scr cleared", A_SCR, 32'h0, 1'b1, OKAY, rd, hs);

        // Failing exit, then a later TOHOST write is ignored.
        axi_write("tohost fail", A_HOST, 32'h0000_0007, 4'hF, OKAY);
        check("fail status", 64'({done, pass, exit_code}), 64'({1'b1, 1'b0, 31'd3}));
        axi_write("tohost after done", A_HOST, 32'h0000_0001, 4'hF, OKAY);
        check("status kept", 64'({done, pass, exit_code}), 64'({1'b1, 1'b0, 31'd3}));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
